// File: rtl/matmul_accum_if.sv
// Product-in / result-out handshake bundle for the matmul accumulation stage.
// master drives products and consumes results; slave is the accumulator side.
interface matmul_accum_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_overflow;
  logic [15:0]       out_index;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, out_index
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_overflow, out_index
  );
endinterface

// File: rtl/matmul_accum.sv
// Sums every K consecutive unsigned products into one saturating dot-product result,
// holding one finished result on a valid/ready output while the next one accumulates.
module matmul_accum #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48,
  parameter int K      = 4
) (
  input logic           clk,
  input logic           rst,
  matmul_accum_if.slave bus
);
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int SUM_W = ACC_W + 1;
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  logic [KW-1:0]    r_k_cnt, w_k_cnt_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [ACC_W-1:0] r_out_data, w_out_data_nxt;
  logic             r_out_ovf, w_out_ovf_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [15:0]      r_out_index, w_out_index_nxt;

  logic             w_last, w_in_ready, w_accept, w_emit;
  logic [SUM_W-1:0] w_sum;
  logic [ACC_W-1:0] w_term_acc;
  logic             w_term_ovf;

  assign w_last     = (r_k_cnt == K_LAST);
  // Only a completing term can collide with an unconsumed result.
  assign w_in_ready = !bus.clear && !(r_out_valid && !bus.out_ready && w_last);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_emit     = r_out_valid && bus.out_ready;
  assign w_sum      = {1'b0, r_acc} + SUM_W'(bus.in_data);

  always_comb begin
    w_term_acc = ACC_W'(bus.in_data);
    w_term_ovf = 1'b0;
    if (r_k_cnt != '0) begin
      w_term_acc = w_sum[SUM_W-1] ? '1 : w_sum[ACC_W-1:0];
      w_term_ovf = w_sum[SUM_W-1] || r_ovf;
    end
  end

  always_comb begin
    w_k_cnt_nxt     = r_k_cnt;
    w_acc_nxt       = r_acc;
    w_ovf_nxt       = r_ovf;
    w_out_data_nxt  = r_out_data;
    w_out_ovf_nxt   = r_out_ovf;
    w_out_valid_nxt = r_out_valid;
    w_out_index_nxt = r_out_index;
    if (w_emit) begin
      w_out_valid_nxt = 1'b0;
      w_out_index_nxt = r_out_index + 16'd1;
    end
    if (bus.clear) begin
      w_k_cnt_nxt = '0;
      w_acc_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else if (w_accept) begin
      w_acc_nxt = w_term_acc;
      w_ovf_nxt = w_term_ovf;
      if (w_last) begin
        w_k_cnt_nxt     = '0;
        w_out_data_nxt  = w_term_acc;
        w_out_ovf_nxt   = w_term_ovf;
        w_out_valid_nxt = 1'b1;
      end else begin
        w_k_cnt_nxt = r_k_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k_cnt     <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
    end else begin
      r_k_cnt     <= w_k_cnt_nxt;
      r_acc       <= w_acc_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_index <= w_out_index_nxt;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_overflow = r_out_ovf;
  assign bus.out_index    = r_out_index;
endmodule

// File: tb/tb_matmul_accum.sv
// Bench for matmul_accum: directed and random steps against a queue-based dot-product model,
// plus a narrow-accumulator saturation instance and a K=1 index-wrap instance.
module tb_matmul_accum;
  localparam int K0 = 4;
  localparam logic [63:0] MAX48 = 64'h0000_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matmul_accum_if #(.DATA_W(32), .ACC_W(48)) b0 ();
  matmul_accum_if #(.DATA_W(32), .ACC_W(33)) b1 ();
  matmul_accum_if #(.DATA_W(32), .ACC_W(48)) b2 ();

  matmul_accum #(.DATA_W(32), .ACC_W(48), .K(K0)) u0 (.clk(clk), .rst(rst_n), .bus(b0));
  matmul_accum #(.DATA_W(32), .ACC_W(33), .K(4))  u1 (.clk(clk), .rst(rst_n), .bus(b1));
  matmul_accum #(.DATA_W(32), .ACC_W(48), .K(1))  u2 (.clk(clk), .rst(rst_n), .bus(b2));

  int tests = 0;
  int failed = 0;

  // Reference: terms of the dot product in progress, and the result being held.
  logic [31:0] m_terms[$];
  logic        m_hold;
  logic [63:0] m_out;
  logic        m_ovf;
  logic [15:0] m_idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_terms.delete();
    m_hold = 1'b0;
    m_out  = '0;
    m_ovf  = 1'b0;
    m_idx  = '0;
  endtask

  task automatic reduce(output logic [63:0] s, output logic o);
    s = '0;
    o = 1'b0;
    foreach (m_terms[i]) begin
      s = s + 64'(m_terms[i]);
      if (s > MAX48) begin
        s = MAX48;
        o = 1'b1;
      end
    end
  endtask

  task automatic step0(input logic v, input logic [31:0] d, input logic ordy, input logic clr);
    logic exp_rdy, acc, emit, done;
    b0.in_valid  = v;
    b0.in_data   = d;
    b0.out_ready = ordy;
    b0.clear     = clr;
    #4;
    exp_rdy = !clr && !(m_hold && !ordy && m_terms.size() == K0 - 1);
    chk("in_ready", 64'(b0.in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(b0.out_valid), 64'(m_hold));
    if (m_hold) begin
      chk("out_data", 64'(b0.out_data), m_out);
      chk("out_overflow", 64'(b0.out_overflow), 64'(m_ovf));
      chk("out_index", 64'(b0.out_index), 64'(m_idx));
    end
    acc  = v && exp_rdy;
    emit = m_hold && ordy;
    done = 1'b0;
    if (emit) m_idx = m_idx + 16'd1;
    if (clr) m_terms.delete();
    else if (acc) begin
      m_terms.push_back(d);
      if (m_terms.size() == K0) begin
        reduce(m_out, m_ovf);
        m_terms.delete();
        done = 1'b1;
      end
    end
    if (done) m_hold = 1'b1;
    else if (emit) m_hold = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.clear = 0; b0.in_valid = 0; b0.in_data = '0; b0.out_ready = 0;
    b1.clear = 0; b1.in_valid = 0; b1.in_data = '0; b1.out_ready = 0;
    b2.clear = 0; b2.in_valid = 0; b2.in_data = '0; b2.out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(b0.in_ready), 64'd1);
    chk("rst_out_valid", 64'(b0.out_valid), 64'd0);
    chk("rst_out_data", 64'(b0.out_data), 64'd0);
    chk("rst_out_overflow", 64'(b0.out_overflow), 64'd0);
    chk("rst_out_index", 64'(b0.out_index), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic sum
    step0(1, 5, 1, 0);
    step0(1, 10, 1, 0);
    step0(1, 15, 1, 0);
    chk("basic_not_early", 64'(b0.out_valid), 64'd0);
    step0(1, 2, 1, 0);
    chk("basic_valid", 64'(b0.out_valid), 64'd1);
    chk("basic_data", 64'(b0.out_data), 64'd32);
    chk("basic_ovf", 64'(b0.out_overflow), 64'd0);
    chk("basic_index", 64'(b0.out_index), 64'd0);

    // Back-to-back results with no stall or bubble
    for (int i = 1; i <= 8; i++) begin
      step0(1, 32'(i), 1, 0);
      if (i == 4) chk("b2b_first", 64'(b0.out_data), 64'd10);
      if (i == 8) begin
        chk("b2b_second", 64'(b0.out_data), 64'd26);
        chk("b2b_index", 64'(b0.out_index), 64'd2);
      end
    end
    step0(0, 0, 1, 0);
    chk("b2b_drained", 64'(b0.out_valid), 64'd0);

    // Backpressure
    for (int i = 1; i <= 4; i++) step0(1, 32'(i), 1, 0);
    for (int i = 5; i <= 7; i++) step0(1, 32'(i), 0, 0);
    step0(1, 8, 0, 0);
    chk("bp_held_data", 64'(b0.out_data), 64'd10);
    step0(1, 8, 0, 0);
    chk("bp_held_index", 64'(b0.out_index), 64'd3);
    step0(1, 8, 1, 0);
    chk("bp_second_valid", 64'(b0.out_valid), 64'd1);
    chk("bp_second_data", 64'(b0.out_data), 64'd26);
    chk("bp_second_index", 64'(b0.out_index), 64'd4);
    step0(0, 0, 1, 0);

    // Clear discards the partial sum and blocks the cycle's input
    step0(1, 7, 1, 0);
    step0(1, 9, 1, 0);
    step0(1, 100, 1, 1);
    for (int i = 1; i <= 4; i++) step0(1, 32'(i), 1, 0);
    chk("clear_data", 64'(b0.out_data), 64'd10);
    step0(0, 0, 1, 0);

    // Asynchronous reset with a held result and a partial sum
    for (int i = 1; i <= 4; i++) step0(1, 32'(i), 0, 0);
    step0(1, 7, 0, 0);
    step0(1, 9, 0, 0);
    b0.in_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(b0.out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(b0.out_data), 64'd0);
    chk("mid_rst_out_index", 64'(b0.out_index), 64'd0);
    chk("mid_rst_in_ready", 64'(b0.in_ready), 64'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) step0(1, 32'(i), 1, 0);
    chk("post_rst_data", 64'(b0.out_data), 64'd10);
    chk("post_rst_index", 64'(b0.out_index), 64'd0);
    step0(0, 0, 1, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      step0($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
    step0(0, 0, 1, 0);

    // Saturation on a 33-bit accumulator
    b1.out_ready = 1;
    b1.in_valid  = 1;
    b1.in_data   = 32'hFFFF_FFFF;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("sat_valid", 64'(b1.out_valid), 64'd1);
    chk("sat_data", 64'(b1.out_data), 64'h1_FFFF_FFFF);
    chk("sat_ovf", 64'(b1.out_overflow), 64'd1);
    b1.in_data = 32'd1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("unsat_data", 64'(b1.out_data), 64'd4);
    chk("unsat_ovf", 64'(b1.out_overflow), 64'd0);
    b1.in_valid = 0;

    // K=1 index wrap
    b2.out_ready = 1;
    b2.in_valid  = 1;
    for (int i = 0; i < 65537; i++) begin
      b2.in_data = 32'(i);
      @(posedge clk);
      #1;
      if (i == 0 || i == 65535 || i == 65536) begin
        chk("wrap_index", 64'(b2.out_index), 64'(i & 16'hFFFF));
        chk("wrap_data", 64'(b2.out_data), 64'(i));
      end
    end
    b2.in_valid = 0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/matmul_accum.md
# matmul_accum

Downstream accumulation stage for the `mat` multiplier. It consumes the 32-bit product stream, sums every K consecutive products into one dot-product result (one output matrix element), and presents each result on a valid/ready output with a running element index. It saturates on overflow and holds one completed result while the next dot product accumulates.

## Interface
- `DATA_W`, 32, width of each incoming product (unsigned).
- `ACC_W`, 48, accumulator and result width; must be ≥ `DATA_W`.
- `K`, 4, number of products per dot product; must be ≥ 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low. It clears all state immediately.
- `clear`  in  1  synchronous discard of the partial sum in progress.
- `in_valid`  in  1  product on `in_data` is valid.
- `in_ready`  out  1  stage accepts a product this cycle.
- `in_data`  in  DATA_W  product from the multiplier.
- `out_valid`  out  1  completed result is held on the outputs.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out_data`  out  ACC_W  dot-product result.
- `out_overflow`  out  1  result saturated.
- `out_index`  out  16  ordinal of this result, starting at 0 after reset.

## Operation
- Accept occurs when `in_valid && in_ready`. Emit occurs when `out_valid && out_ready`.
- State machine: COLLECT (`k_cnt` 0..K-1) and the output register's `out_valid` flag. Input and output proceed independently except as stalled below.
- On an accept with `k_cnt==0`: `acc = zero-extend(in_data)` and `ovf = 0`.
- On an accept with `k_cnt>0`: `acc = acc + in_data` as an unsigned sum.
  - If the sum carries past ACC_W bits, `acc` becomes all-ones and `ovf` is set (sticky).
  - Once `acc` is saturated it stays all-ones.
- When the accepted term is term K (`k_cnt==K-1`):
  - The final sum, including this term, loads `out_data` and `out_overflow`.
  - `out_valid` is set.
  - `k_cnt` returns to 0.
  - For K=1, every accept loads the output directly.
- `in_ready = !clear && !(out_valid && !out_ready && k_cnt==K-1)`. Input stalls only when a completing term would overwrite an unconsumed result. Non-final terms are always accepted.
- An emit with no new completion that cycle clears `out_valid`. A completion in the same cycle as an emit reloads the output and keeps `out_valid` at 1, so there is no bubble.
- `out_index` increments by 1 on each emit and wraps from 0xFFFF to 0x0000.
- `clear`:
  - Sets `k_cnt=0`, `acc=0`, `ovf=0`.
  - Forces `in_ready` low, so no product is accepted that cycle.
  - Does not affect the output register, `out_valid`, or `out_index`.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_data=0`, `out_overflow=0`, `out_index=0`, `k_cnt=0`, `acc=0`.
- Latency: `out_valid` rises the cycle after the clock edge that accepts term K.
- Throughput: one product per cycle sustained while `out_ready` is held high.
- Outputs are registered. `in_ready` is combinational from `clear`, `out_ready`, and state.
- `out_data`, `out_overflow`, and `out_index` are stable while `out_valid && !out_ready`.
- Reset asserted mid-accumulation or mid-hold discards everything. After release, the first accepted product starts a new dot product with index 0.

## Test plan
- Basic sum: K=4, products 5, 10, 15, 2 back-to-back with `out_ready=1` -> `out_data=32`, `out_overflow=0`, `out_index=0`; `out_valid` is high exactly one cycle after the 4th accept.
- Back-to-back results: 8 products 1..8 with `out_ready=1` -> results 10 (index 0) then 26 (index 1), with no input stall and no output bubble.
- Saturation: ACC_W=33, K=4, four products of 0xFFFFFFFF -> `out_data=0x1FFFFFFFF`, `out_overflow=1`. The next dot product of 1, 1, 1, 1 -> `out_data=4`, `out_overflow=0`.
- Backpressure:
  - Hold `out_ready=0` after the first result; feed 4 more products.
  - Products 1-3 are accepted; `in_ready` drops at product 4 and the held result is unchanged.
  - Raise `out_ready` -> first result is emitted in that cycle, product 4 is accepted, and the second result appears on the next cycle.
- Clear and reset: after 2 of 4 terms (7, 9), pulse `clear`; `in_valid` stays high during the pulse and no product is accepted. Then feed 1, 2, 3, 4 -> result 10.
  - Repeat with `rst` low after 2 terms -> all outputs return to their reset values immediately, and the next result has index 0.
- Index wrap: run 65537 K=1 results -> `out_index` goes 0xFFFF then 0x0000.
